serial_addsub_seq: RTL and testbench
====================================

Name: serial_addsub_seq

Overview:
- Multi-cycle WIDTH-bit add/subtract sequencer that drives a single 4-bit carry-lookahead slice one nibble per cycle, LSB nibble first.
- Sits directly upstream of that slice in the ALU datapath. It registers operands, issues nibble operands plus carry-in, collects nibble sums and carry-out, and presents the full result with status flags.
- Trades latency for area: one slice is reused instead of WIDTH/4 slices in parallel.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4 (derived, localparam), number of slice passes per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- sub  input  1  1 = A-B, 0 = A+B; sampled with the operands
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference
- carry_out  output  1  final carry; for subtract, 1 = no borrow
- overflow  output  1  signed overflow (see Optional Feature)
- zero  output  1  result == 0 (see Optional Feature)

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset enters IDLE asynchronously.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, carry_out 0, overflow 0, zero 0, nibble counter 0, carry register 0.
- IDLE:
  - in_ready = 1; all other cycles in_ready = 0.
  - On in_valid & in_ready: latch op_a, the effective B (op_b ^ {WIDTH{sub}}) and sub.
  - Set carry register = sub, counter = 0, go to RUN.
  - in_valid without in_ready is ignored; no operand change is observed.
- RUN:
  - Slice inputs are nibble[counter] of latched A, nibble[counter] of effective B, and the carry register; the slice is combinational.
  - Each clock, write the slice sum into result nibble[counter] and load the carry register with the slice carry-out.
  - counter increments; when counter == NIB-1, go to DONE and set carry_out from that cycle's slice carry-out.
  - Exactly NIB cycles in RUN.
- DONE:
  - out_valid = 1; result, carry_out and flags are held stable while out_valid & !out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid drops next cycle, result keeps its value.
- Latency: acceptance edge at cycle 0 gives out_valid = 1 in cycle NIB+1 (cycle 5 for WIDTH = 16).
- Throughput: at most one operation per NIB+2 cycles.
- No input/output overlap: in_ready is 0 during RUN and DONE. Simultaneous in_valid while in DONE is not accepted until IDLE.
- Intermediate result nibbles are visible on result during RUN; out_valid = 0 qualifies them as invalid.
- Counter width is clog2(NIB); it never wraps past NIB-1.
- Reset mid-RUN or mid-DONE aborts the operation: outputs return to reset values immediately, and no partial result is ever flagged valid.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined:
  - overflow = (A[msb] == Beff[msb]) & (result[msb] != A[msb]).
  - zero = (result == 0).
  - Both are registered on entry to DONE and valid with out_valid.
- Not defined: overflow and zero are tied to 0; no flag logic is synthesised. The ports stay present so the interface is unchanged.

Decomposition:
- Shared package alu_pkg:
  - FSM state typedef (IDLE/RUN/DONE encoding).
  - constant NIBBLE_W = 4.
  - op encoding constants OP_ADD = 0, OP_SUB = 1.
- One sub-module: the existing cla_4bit slice, instantiated once. The sequencer contains no adder logic of its own.

Test Plan (WIDTH = 16):
- Add 0x1234 + 0x4321, out_ready = 1 -> out_valid in cycle 5 after accept; result 0x5555, carry_out 0, overflow 0, zero 0; in_ready back to 1 one cycle after the out handshake.
- Add 0xFFFF + 0x0001 -> result 0x0000, carry_out 1, zero 1, overflow 0; confirms carry ripples across all 4 nibble passes.
- Add 0x7FFF + 0x0001 -> result 0x8000, carry_out 0, overflow 1; sub 0x8000 - 0x0001 -> 0x7FFF, carry_out 1, overflow 1 (flags checked with ALU_FLAGS_EN; both 0 without).
- Sub 0x0005 - 0x0007 -> result 0xFFFE, carry_out 0 (borrow), overflow 0. Back-to-back requests with in_valid held high -> second accepted only when in_ready = 1, with correct result.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE -> result, carry_out and flags stable, out_valid = 1, in_ready = 0; change op_a during this time -> no effect.
- Assert rst_n = 0 asynchronously during the 2nd RUN cycle -> out_valid 0 and in_ready 1 immediately; after release, a new 0x0001 + 0x0001 gives 0x0002 with no residue from the aborted operation.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, nibble width and op codes.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice; purely combinational, no backpressure.
module cla_4bit
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum-of-products of generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/serial_addsub_seq.sv
// WIDTH-bit add/sub through one cla_4bit slice, LSB nibble first; out_valid NIB+1 cycles after accept.
// Result held while out_ready is low; in_ready only in IDLE. ALU_FLAGS_EN enables overflow/zero flags.
module serial_addsub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                last_nib;

  assign slice_a  = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
  assign slice_b  = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];
  assign last_nib = (cnt_q == CNT_W'(NIB - 1));

  cla_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // B is stored already inverted for subtract; carry-in of 1 completes two's complement.
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{sub}};
          carry_d = (sub == OP_SUB);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[cnt_q*NIBBLE_W +: NIBBLE_W] = slice_sum;
        carry_d = slice_cout;
        if (last_nib) begin
          carry_out_d = slice_cout;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

`ifdef ALU_FLAGS_EN
  logic overflow_q, overflow_d;
  logic zero_q, zero_d;

  // Flags are taken from the fully assembled result on the last slice pass.
  always_comb begin
    overflow_d = overflow_q;
    zero_d     = zero_q;
    if ((state_q == RUN) && last_nib) begin
      overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
      zero_d     = (result_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign overflow = overflow_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for serial_addsub_seq (WIDTH = 16): latency, arithmetic, flags, backpressure, async reset.
module tb_serial_addsub_seq;

  localparam int W = 16;
`ifdef ALU_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int errors = 0;
  int checks = 0;

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operation and return one cycle after its accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    op_a = a;
    op_b = b;
    sub = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic collect(input string tag, input logic [W-1:0] er, input logic ec,
                         input logic eo, input logic ez, input int hold);
    int cyc;
    cyc = 1;
    out_ready = (hold == 0);
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 32'd5);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, er});
    chk({tag, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo & FL});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez & FL});
    chk({tag, "_inrdy_busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op_a = 16'h3C3C ^ W'(i);
      op_b = 16'h0101;
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_res"}, {16'd0, result}, {16'd0, er});
      chk({tag, "_hold_c"}, {30'd0, carry_out, overflow}, {30'd0, ec, eo & FL});
      chk({tag, "_hold_z"}, {31'd0, zero}, {31'd0, ez & FL});
    end
    if (hold > 0) in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_post_vld"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_post_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_post_res"}, {16'd0, result}, {16'd0, er});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inrdy", {31'd0, in_ready}, 32'd1);
    chk("rst_outvld", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain add, no carries between nibbles.
    issue(16'h1234, 16'h4321, 1'b0);
    in_valid = 1'b0;
    collect("add_basic", 16'h5555, 1'b0, 1'b0, 1'b0, 0);

    // Carry ripples through all four passes.
    issue(16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    collect("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 0);

    issue(16'h7FFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    collect("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 0);

    issue(16'h8000, 16'h0001, 1'b1);
    in_valid = 1'b0;
    collect("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);

    issue(16'h0005, 16'h0007, 1'b1);
    in_valid = 1'b0;
    collect("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);

    // Back-to-back: in_valid stays high, second op waits for IDLE.
    issue(16'h00FF, 16'h0F01, 1'b0);
    op_a = 16'h1000;
    op_b = 16'h0001;
    sub = 1'b1;
    collect("b2b_first", 16'h1000, 1'b0, 1'b0, 1'b0, 0);
    issue(16'h1000, 16'h0001, 1'b1);
    in_valid = 1'b0;
    collect("b2b_second", 16'h0FFF, 1'b1, 1'b0, 1'b0, 0);

    // Backpressure with operand changes during DONE.
    issue(16'h9000, 16'h9000, 1'b0);
    in_valid = 1'b0;
    collect("bp", 16'h2000, 1'b1, 1'b1, 1'b0, 3);

    // Async reset during the second RUN cycle.
    issue(16'h1234, 16'h4321, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outvld", {31'd0, out_valid}, 32'd0);
    chk("abort_inrdy", {31'd0, in_ready}, 32'd1);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_carry", {31'd0, carry_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h0001, 16'h0001, 1'b0);
    in_valid = 1'b0;
    collect("after_rst", 16'h0002, 1'b0, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
